// File: rtl/mul16_pkg.sv
// Shared definitions for the mul16 shift-and-add multiplier: FSM state
// encodings and the number of RUN steps per multiply.
package mul16_pkg;

    typedef enum logic [1:0] {
        MUL16_IDLE = 2'd0,
        MUL16_RUN  = 2'd1,
        MUL16_DONE = 2'd2
    } mul16_state_e;

    localparam int MUL16_STEPS = 16;

    localparam logic [3:0] MUL16_LAST_COUNT = 4'(MUL16_STEPS - 1);

endpackage

// File: rtl/mul16_add16.sv
// add16: 16-bit adder used as the mul16 accumulator adder.
// The carry-out is dropped, so all sums wrap mod 2^16.
module add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul16.sv
// mul16: sequential shift-and-add 16x16 multiplier returning (a*b) mod 2^16.
// The result is the same for unsigned and two's-complement operands.
// Optional feature macro MUL16_EARLY_EXIT_EN: leave RUN as soon as no
// multiplier bits remain, and skip RUN entirely when b == 0.
module mul16
    import mul16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    mul16_state_e state_q, state_d;
    logic [15:0]  mcand_q, mcand_d;
    logic [15:0]  mult_q, mult_d;
    logic [15:0]  acc_q, acc_d;
    logic [3:0]   count_q, count_d;
    logic [15:0]  out_q, out_d;
    logic [15:0]  sum;
    logic         take;
    logic         last_step;
    logic         skip_run;

    add16 u_add16 (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .sum_o (sum)
    );

    // A new operation can only be accepted while not running.
    assign take = start && (state_q != MUL16_RUN);

`ifdef MUL16_EARLY_EXIT_EN
    // Stop when the shifted multiplier has no set bits left; b == 0 never runs.
    assign last_step = (count_q == MUL16_LAST_COUNT) || ((mult_q >> 1) == 16'h0000);
    assign skip_run  = (b == 16'h0000);
`else
    assign last_step = (count_q == MUL16_LAST_COUNT);
    assign skip_run  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MUL16_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL16_IDLE, MUL16_DONE: begin
                if (take) begin
                    state_d = skip_run ? MUL16_DONE : MUL16_RUN;
                end else begin
                    state_d = MUL16_IDLE;
                end
            end
            MUL16_RUN: begin
                if (last_step) begin
                    state_d = MUL16_DONE;
                end
            end
            default: state_d = MUL16_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy = (state_q == MUL16_RUN);
        done = (state_q == MUL16_DONE);
        out  = out_q;
    end

    // Datapath next-state: operand capture, one shift-and-add step per RUN cycle.
    always_comb begin
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        count_d = count_q;
        out_d   = out_q;
        if (take) begin
            mcand_d = a;
            mult_d  = b;
            acc_d   = 16'h0000;
            count_d = 4'd0;
            if (skip_run) begin
                out_d = 16'h0000;
            end
        end else if (state_q == MUL16_RUN) begin
            acc_d   = mult_q[0] ? sum : acc_q;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            count_d = count_q + 4'd1;
            // Publish the final accumulator on the edge that enters DONE.
            if (last_step) begin
                out_d = acc_d;
            end
        end
    end

    // Datapath registers; reset clears everything, aborting any running op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= 16'h0000;
            mult_q  <= 16'h0000;
            acc_q   <= 16'h0000;
            count_q <= 4'd0;
            out_q   <= 16'h0000;
        end else begin
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

endmodule
